// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner: FSM states,
// hex-to-segment table and the all-dark segment pattern.
package seg_pkg;

  typedef enum logic {
    ST_GAP = 1'b0,
    ST_ON  = 1'b1
  } seg_state_e;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low a..g in bits 0..6; bit 7 (dp) is stored as off.
  localparam logic [7:0] HEX_SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_hex_dec.sv
// Combinational nibble + decimal point + blank to active-low segment decoder.
module seg_hex_dec
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);

  always_comb begin
    seg = HEX_SEG[nibble] & {~dp, 7'h7F};
    if (blank) begin
      seg = SEG_OFF;
    end
  end

endmodule

// File: rtl/seg_scan.sv
// Multiplexed seven-segment scanner with anti-ghosting gap and frame-aligned
// double-buffered display data.
module seg_scan
  import seg_pkg::*;
#(
  parameter int NUM_DIG = 8,
  parameter int DIV     = 50000,
  parameter int GAP     = 500
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_en,
  input  logic                   i_load,
  input  logic [4*NUM_DIG-1:0]   i_data,
  input  logic [NUM_DIG-1:0]     i_dp,
  input  logic [NUM_DIG-1:0]     i_blank,
  output logic [NUM_DIG-1:0]     o_seg_com,
  output logic [7:0]             o_seg_d,
  output logic                   o_frame_done
);

  localparam int DW = cnt_width(DIV);
  // Gap counter holds GAP itself: after reset it starts one step earlier
  // so the first common goes low on edge GAP+1.
  localparam int GW = cnt_width(GAP + 1);
  localparam int IW = cnt_width(NUM_DIG);

  seg_state_e              state_q, state_n;
  logic [IW-1:0]           idx_q, idx_n;
  logic [DW-1:0]           div_cnt_q, div_cnt_n;
  logic [GW-1:0]           gap_cnt_q, gap_cnt_n;
  logic                    done_n;

  logic [4*NUM_DIG-1:0]    act_data_q, act_data_n, pend_data_q;
  logic [NUM_DIG-1:0]      act_dp_q, act_dp_n, pend_dp_q;
  logic [NUM_DIG-1:0]      act_blank_q, act_blank_n, pend_blank_q;
  logic                    pend_valid_q;

  logic [3:0]              sel_nib;
  logic                    sel_dp;
  logic                    sel_blank;
  logic [NUM_DIG-1:0]      com_n;
  logic [7:0]              seg_dec;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= ST_GAP;
      idx_q     <= '0;
      div_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_n;
      idx_q     <= idx_n;
      div_cnt_q <= div_cnt_n;
      gap_cnt_q <= gap_cnt_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    idx_n     = idx_q;
    div_cnt_n = div_cnt_q;
    gap_cnt_n = gap_cnt_q;
    if (!i_en) begin
      state_n   = ST_GAP;
      idx_n     = '0;
      div_cnt_n = '0;
      gap_cnt_n = '0;
    end else begin
      case (state_q)
        ST_GAP: begin
          if (gap_cnt_q == GW'(GAP)) begin
            state_n   = ST_ON;
            div_cnt_n = '0;
            gap_cnt_n = '0;
          end else begin
            gap_cnt_n = gap_cnt_q + 1'b1;
          end
        end
        ST_ON: begin
          if (div_cnt_q == DW'(DIV - 1)) begin
            div_cnt_n = '0;
            idx_n     = (idx_q == IW'(NUM_DIG - 1)) ? '0 : idx_q + 1'b1;
            if (GAP != 0) begin
              state_n   = ST_GAP;
              gap_cnt_n = GW'(1);
            end
          end else begin
            div_cnt_n = div_cnt_q + 1'b1;
          end
        end
        default: state_n = ST_GAP;
      endcase
    end
    done_n = (state_n == ST_ON) && (idx_n == IW'(NUM_DIG - 1)) &&
             (div_cnt_n == DW'(DIV - 1));
  end

  // Swap into the active set only at the frame boundary; a load in that
  // same cycle bypasses the pending register.
  always_comb begin
    act_data_n  = act_data_q;
    act_dp_n    = act_dp_q;
    act_blank_n = act_blank_q;
    if (o_frame_done) begin
      if (i_load) begin
        act_data_n  = i_data;
        act_dp_n    = i_dp;
        act_blank_n = i_blank;
      end else if (pend_valid_q) begin
        act_data_n  = pend_data_q;
        act_dp_n    = pend_dp_q;
        act_blank_n = pend_blank_q;
      end
    end
  end

  always_comb begin
    sel_nib   = '0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    com_n     = '1;
    for (int unsigned k = 0; k < NUM_DIG; k++) begin
      if (idx_n == IW'(k)) begin
        sel_nib   = act_data_n[4*k +: 4];
        sel_dp    = act_dp_n[k];
        sel_blank = act_blank_n[k];
        com_n[k]  = 1'b0;
      end
    end
    if (state_n != ST_ON) begin
      com_n = '1;
    end
  end

  seg_hex_dec u_dec (
    .nibble (sel_nib),
    .dp     (sel_dp),
    .blank  (sel_blank),
    .seg    (seg_dec)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pend_valid_q <= 1'b0;
      o_seg_com    <= '1;
      o_seg_d      <= SEG_OFF;
      o_frame_done <= 1'b0;
    end else begin
      act_data_q  <= act_data_n;
      act_dp_q    <= act_dp_n;
      act_blank_q <= act_blank_n;
      if (o_frame_done) begin
        pend_valid_q <= 1'b0;
      end else if (i_load) begin
        pend_data_q  <= i_data;
        pend_dp_q    <= i_dp;
        pend_blank_q <= i_blank;
        pend_valid_q <= 1'b1;
      end
      o_seg_com    <= com_n;
      o_seg_d      <= (state_n == ST_ON) ? seg_dec : SEG_OFF;
      o_frame_done <= done_n;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: a time-based reference model predicts every
// cycle's outputs, a negedge monitor compares them.
module tb_seg_scan;

  localparam int N   = 4;
  localparam int DIV = 8;
  localparam int GAP = 2;
  localparam int PER = DIV + GAP;

  typedef struct packed {
    logic [3:0] com;
    logic [7:0] seg;
    logic       done;
  } exp_t;

  logic        i_clk;
  logic        i_rstn;
  logic        i_en;
  logic        i_load;
  logic [15:0] i_data;
  logic [3:0]  i_dp;
  logic [3:0]  i_blank;
  logic [3:0]  o_seg_com;
  logic [7:0]  o_seg_d;
  logic        o_frame_done;

  seg_scan #(.NUM_DIG(N), .DIV(DIV), .GAP(GAP)) dut (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_en         (i_en),
    .i_load       (i_load),
    .i_data       (i_data),
    .i_dp         (i_dp),
    .i_blank      (i_blank),
    .o_seg_com    (o_seg_com),
    .o_seg_d      (o_seg_d),
    .o_frame_done (o_frame_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic [7:0] hex_ref [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // Reference model: what is shown, what is queued, edges since enable.
  logic [15:0] m_data, p_data;
  logic [3:0]  m_dp, m_blank, p_dp, p_blank;
  logic        m_pv;
  logic        m_done;
  int          m_e;
  int          cur_d, cur_ph;

  exp_t q[$];
  exp_t mx;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_seg(input int d);
    logic [3:0] nib;
    logic [7:0] s;
    nib  = m_data[4*d +: 4];
    s    = hex_ref[nib];
    s[7] = ~m_dp[d];
    if (m_blank[d]) s = 8'hFF;
    return s;
  endfunction

  task automatic model_edge();
    exp_t x;
    int   u, ph, d;
    if (!i_rstn) begin
      m_data = '0; m_dp = '0; m_blank = '0;
      p_data = '0; p_dp = '0; p_blank = '0;
      m_pv = 1'b0; m_e = 0;
    end else begin
      if (m_done) begin
        if (i_load) begin
          m_data = i_data; m_dp = i_dp; m_blank = i_blank;
        end else if (m_pv) begin
          m_data = p_data; m_dp = p_dp; m_blank = p_blank;
        end
        m_pv = 1'b0;
      end else if (i_load) begin
        p_data = i_data; p_dp = i_dp; p_blank = i_blank;
        m_pv = 1'b1;
      end
      m_e = i_en ? m_e + 1 : 0;
    end
    x.com  = 4'hF;
    x.seg  = 8'hFF;
    x.done = 1'b0;
    cur_d  = -1;
    cur_ph = -1;
    if (m_e > GAP) begin
      u  = m_e - GAP - 1;
      ph = u % PER;
      d  = (u / PER) % N;
      if (ph < DIV) begin
        x.com[d] = 1'b0;
        x.seg    = ref_seg(d);
        x.done   = (d == N - 1) && (ph == DIV - 1);
        cur_d    = d;
        cur_ph   = ph;
      end
    end
    m_done = x.done;
    q.push_back(x);
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_edge();
    #1;
    i_load = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    i_data  = d;
    i_dp    = dp;
    i_blank = bl;
    i_load  = 1'b1;
    tick();
  endtask

  task automatic wait_digit(input int d, input int ph);
    int n = 0;
    while (!(cur_d == d && cur_ph == ph) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_digit%0d: got timeout expected digit reached", d);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!m_done && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_done: got timeout expected frame end");
    end
  endtask

  always @(negedge i_clk) begin
    if (q.size() > 0) begin
      mx = q.pop_front();
      chk("com",  {28'b0, o_seg_com},    {28'b0, mx.com});
      chk("seg",  {24'b0, o_seg_d},      {24'b0, mx.seg});
      chk("done", {31'b0, o_frame_done}, {31'b0, mx.done});
    end
  end

  initial begin
    i_rstn = 1'b0; i_en = 1'b0; i_load = 1'b0;
    i_data = '0; i_dp = '0; i_blank = '0;
    m_data = '0; m_dp = '0; m_blank = '0;
    p_data = '0; p_dp = '0; p_blank = '0;
    m_pv = 1'b0; m_done = 1'b0; m_e = 0; cur_d = -1; cur_ph = -1;

    run(3);
    i_rstn = 1'b1;
    i_en   = 1'b1;
    load(16'h3210, 4'b0000, 4'b0000);
    run(90);

    wait_digit(1, 3);
    load(16'hFEDC, 4'b0000, 4'b0000);
    run(60);

    wait_done();
    load(16'hA5B7, 4'b1001, 4'b0000);
    run(50);

    load(16'h3210, 4'b0100, 4'b1000);
    run(90);

    wait_digit(2, 4);
    i_en = 1'b0;
    run(6);
    i_en = 1'b1;
    run(50);

    wait_digit(1, 2);
    load(16'h9999, 4'b1111, 4'b0000);
    #5;
    i_rstn = 1'b0;
    #1;
    chk("rst_com",  {28'b0, o_seg_com},    32'h0000_000F);
    chk("rst_seg",  {24'b0, o_seg_d},      32'h0000_00FF);
    chk("rst_done", {31'b0, o_frame_done}, 32'h0);
    tick();
    i_rstn = 1'b1;
    run(100);

    for (int unsigned c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 24) == 0) begin
        i_data  = 16'($urandom);
        i_dp    = 4'($urandom);
        i_blank = 4'($urandom & $urandom);
        i_load  = 1'b1;
      end
      if (i_en && $urandom_range(0, 299) == 0) i_en = 1'b0;
      else if (!i_en && $urandom_range(0, 9) == 0) i_en = 1'b1;
      tick();
    end

    i_en = 1'b1;
    run(5);
    @(negedge i_clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter NUM_DIG, default 8, number of multiplexed digits; legal range 1..16.
REQ-002 Parameter DIV, default 50000, clock cycles per digit on-time; DIV >= 1.
REQ-003 Parameter GAP, default 500, all-commons-off cycles between digits (anti-ghosting); GAP >= 0, and GAP = 0 removes the gap.
REQ-004 i_clk  input  1  single clock; all state changes on rising edge.
REQ-005 i_rstn  input  1  asynchronous, active-low reset.
REQ-006 i_en  input  1  1 = scanning; 0 = display dark.
REQ-007 i_load  input  1  single-cycle strobe capturing i_data/i_dp/i_blank into the pending register.
REQ-008 i_data  input  4*NUM_DIG  hex nibble per digit; digit k = bits [4k+3:4k].
REQ-009 i_dp  input  NUM_DIG  decimal point per digit, 1 = lit.
REQ-010 i_blank  input  NUM_DIG  1 = digit k fully dark.
REQ-011 o_seg_com  output  NUM_DIG  active-low digit commons; at most one bit low at any time.
REQ-012 o_seg_d  output  8  active-low segments: bit0..6 = a..g, bit7 = dp.
REQ-013 o_frame_done  output  1  one-cycle pulse at the end of the last digit's on-time.

Function
REQ-014 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-015 FSM states SHALL be ST_GAP (all commons high, o_seg_d = 8'hFF) and ST_ON (o_seg_com[idx] low, o_seg_d = decode of active digit idx).
REQ-016 ST_ON SHALL last exactly DIV cycles, then go to ST_GAP, or, if GAP = 0, directly to ST_ON of the next digit.
REQ-017 ST_GAP SHALL last exactly GAP cycles, then go to ST_ON with the incremented idx.
REQ-018 idx SHALL increment at each ST_ON exit and wrap from NUM_DIG-1 to 0.
REQ-019 Frame period SHALL be exactly NUM_DIG*(DIV+GAP) cycles.
REQ-020 Decode, active-low: 0->C0, 1->F9, 2->A4, 3->B0, 4->99, 5->92, 6->82, 7->F8, 8->80, 9->90, A->88, b->83, C->C6, d->A1, E->86, F->8E.
REQ-021 Bit 7 of o_seg_d SHALL be ~dp[idx].
REQ-022 i_blank[idx] = 1 SHALL force o_seg_d = 8'hFF, dp included; the common is still driven.
REQ-023 i_load = 1 SHALL capture the inputs into the pending register and set pending_valid; a later load overwrites the pending values.
REQ-024 Pending SHALL transfer to the active register on the o_frame_done cycle only, clearing pending_valid, so a frame is never torn.
REQ-025 If i_load coincides with the o_frame_done cycle, the newly presented values SHALL be transferred directly to the active register.
REQ-026 i_en = 0 SHALL, at the next edge, force all commons high, o_seg_d = 8'hFF, state ST_GAP, idx = 0 and the counters cleared; loads still apply.
REQ-027 Re-asserting i_en SHALL restart scanning from ST_GAP with idx 0, identical to the post-reset sequence.

Reset
REQ-028 While i_rstn = 0: o_seg_com all 1, o_seg_d = 8'hFF, o_frame_done = 0, state ST_GAP, idx = 0, counters 0, active/pending registers 0, pending_valid 0.
REQ-029 Reset asserted mid-frame SHALL darken the display immediately (asynchronously), without waiting for a clock edge.
REQ-030 After release with i_en = 1, o_seg_com[0] SHALL first go low on the GAP+1-th rising edge.

Structure
REQ-031 Package seg_pkg SHALL hold the state encodings, the 16-entry hex-to-segment constant table and SEG_OFF = 8'hFF.
REQ-032 Sub-module seg_hex_dec SHALL be the combinational nibble+dp+blank to 8-bit decoder; seg_scan registers its output.
REQ-033 Counter widths SHALL be $clog2 of DIV, GAP and NUM_DIG, with a minimum width of 1.

Verification (bench: NUM_DIG=4, DIV=8, GAP=2)
REQ-034 Reset release, i_en=1, load data 16'h3210, dp=0, blank=0 -> com pattern E,F,D,F,B,F,7,F per frame with 8 on / 2 off cycles; segs C0,F9,A4,B0; frame period 40 cycles.
REQ-035 Load 16'hFEDC mid-frame -> remaining digits of the current frame still show 3210; the next frame shows C6,A1,86,8E.
REQ-036 Load on the exact o_frame_done cycle -> the next frame shows the new data.
REQ-037 dp=4'b0100, blank=4'b1000 -> digit 2 seg = 24; digit 3 com low with seg FF.
REQ-038 i_en dropped during digit 2 -> next edge: com F, seg FF; re-enable -> com E after 3 edges.
REQ-039 Async reset pulse mid digit 1 -> outputs dark before the next edge; scan restarts at digit 0; pending_valid cleared.
